// File: rtl/tohost_monitor.sv
// Snoops data-memory stores to the riscv-tests tohost word, decodes pass/fail,
// and runs a cycle watchdog that halts the core when the test never reports.
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [3:0]       mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic [1:0]       status,
    output logic             done,
    output logic             halt_req,
    output logic [30:0]      fail_testnum,
    output logic [CNT_W-1:0] cycle_count,
    output logic [7:0]       ignored_wr
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StPass    = 2'd1,
        StFail    = 2'd2,
        StTimeout = 2'd3
    } state_e;

    localparam bit               WdEnable    = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [30:0]      fail_q, fail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       ign_q, ign_d;
    logic             hit;

    // Any enabled byte lane counts as a store; the full word is always decoded.
    assign hit = (|mem_we) && (mem_addr == TOHOST_ADDR);

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        ign_d   = ign_q;
        if (state_q == StRun) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (hit && (mem_wdata == 32'd1)) begin
                state_d = StPass;
            end else if (hit && mem_wdata[0]) begin
                state_d = StFail;
                fail_d  = mem_wdata[31:1];
            end else begin
                // An ignored store still counts even when the watchdog fires.
                if (hit && (ign_q != 8'hFF)) begin
                    ign_d = ign_q + 8'd1;
                end
                if (WdEnable && (cnt_q == TimeoutLast)) begin
                    state_d = StTimeout;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= StRun;
            fail_q  <= '0;
            cnt_q   <= '0;
            ign_q   <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
            ign_q   <= ign_d;
        end
    end

    assign status       = state_q;
    assign done         = (state_q != StRun);
    assign halt_req     = done;
    assign fail_testnum = fail_q;
    assign cycle_count  = cnt_q;
    assign ignored_wr   = ign_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: one instance with a 16-cycle watchdog,
// one with the watchdog disabled, both fed the same store stream.
module tb_tohost_monitor;

    logic        sys_clk;
    logic        sys_rst;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic [1:0]  status, status_n;
    logic        done, done_n;
    logic        halt_req, halt_req_n;
    logic [30:0] fail_testnum, fail_testnum_n;
    logic [31:0] cycle_count, cycle_count_n;
    logic [7:0]  ignored_wr, ignored_wr_n;

    int total = 0;
    int bad   = 0;
    logic [31:0] frozen;

    tohost_monitor #(
        .TOHOST_ADDR   (32'h0000_1000),
        .TIMEOUT_CYCLES(16),
        .CNT_W         (32)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .status      (status),
        .done        (done),
        .halt_req    (halt_req),
        .fail_testnum(fail_testnum),
        .cycle_count (cycle_count),
        .ignored_wr  (ignored_wr)
    );

    tohost_monitor #(
        .TOHOST_ADDR   (32'h0000_1000),
        .TIMEOUT_CYCLES(0),
        .CNT_W         (32)
    ) dut_nowd (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .status      (status_n),
        .done        (done_n),
        .halt_req    (halt_req_n),
        .fail_testnum(fail_testnum_n),
        .cycle_count (cycle_count_n),
        .ignored_wr  (ignored_wr_n)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        sys_rst = 1'b1;
        step(n);
        sys_rst = 1'b0;
    endtask

    task automatic wr(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data);
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = data;
        step(1);
        mem_we    = 4'h0;
        mem_wdata = 32'h0;
    endtask

    initial begin
        sys_rst   = 1'b1;
        mem_we    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;

        // 1: reset then idle
        do_reset(3);
        chk("rst_status", status, 2'd0);
        chk("rst_count", cycle_count, 32'd0);
        chk("rst_done", done, 1'b0);
        step(10);
        chk("idle_status", status, 2'd0);
        chk("idle_done", done, 1'b0);
        chk("idle_halt", halt_req, 1'b0);
        chk("idle_count", cycle_count, 32'd10);
        chk("idle_ign", ignored_wr, 8'd0);
        chk("idle_fail", fail_testnum, 31'd0);

        // 2: pass, then later fail store ignored
        do_reset(1);
        wr(4'hF, 32'h1000, 32'd1);
        chk("pass_status", status, 2'd1);
        chk("pass_done", done, 1'b1);
        chk("pass_halt", halt_req, 1'b1);
        wr(4'hF, 32'h1000, 32'd5);
        chk("pass_sticky", status, 2'd1);
        chk("pass_failnum", fail_testnum, 31'd0);

        // 3: fail via single byte lane, counter freezes
        do_reset(1);
        wr(4'h1, 32'h1000, 32'h0000_0007);
        chk("fail_status", status, 2'd2);
        chk("fail_num", fail_testnum, 31'd3);
        chk("fail_count", cycle_count, 32'd1);
        frozen = 32'd1;
        step(20);
        chk("fail_frozen", cycle_count, frozen);
        chk("fail_sticky", status, 2'd2);

        // 4: ignored stores, other address, and we==0
        do_reset(1);
        wr(4'hF, 32'h1000, 32'h8000_0000);
        wr(4'hF, 32'h1000, 32'h8000_0000);
        wr(4'hF, 32'h1004, 32'h0000_1000);
        wr(4'hF, 32'h1004, 32'h0000_0001);
        wr(4'h0, 32'h1000, 32'h0000_0001);
        chk("ign_status", status, 2'd0);
        chk("ign_count", ignored_wr, 8'd2);
        chk("ign_cycles", cycle_count, 32'd5);

        // 5a: watchdog fires on the 16th edge
        do_reset(1);
        step(15);
        chk("wd_before", status, 2'd0);
        step(1);
        chk("wd_status", status, 2'd3);
        chk("wd_count", cycle_count, 32'd16);
        chk("wd_halt", halt_req, 1'b1);
        step(5);
        chk("wd_frozen", cycle_count, 32'd16);
        chk("nowd_run", status_n, 2'd0);

        // 5b: pass on the 16th edge wins
        do_reset(1);
        step(15);
        wr(4'hF, 32'h1000, 32'd1);
        chk("wd_pass_wins", status, 2'd1);
        chk("wd_pass_count", cycle_count, 32'd16);

        // 5c: fail on the 16th edge wins
        do_reset(1);
        step(15);
        wr(4'hF, 32'h1000, 32'd9);
        chk("wd_fail_wins", status, 2'd2);
        chk("wd_fail_num", fail_testnum, 31'd4);

        // 5d: ignored store on the 16th edge counts, then timeout; later stores dropped
        do_reset(1);
        step(15);
        wr(4'hF, 32'h1000, 32'd2);
        chk("wd_ign_status", status, 2'd3);
        chk("wd_ign_count", ignored_wr, 8'd1);
        wr(4'hF, 32'h1000, 32'd2);
        wr(4'hF, 32'h1000, 32'd3);
        chk("wd_ign_sticky", ignored_wr, 8'd1);
        chk("wd_ign_state", status, 2'd3);
        chk("wd_ign_failnum", fail_testnum, 31'd0);

        // 6: reset while failed, with a pass store in the reset cycle
        do_reset(1);
        wr(4'hF, 32'h1000, 32'd7);
        chk("r6_fail", status, 2'd2);
        sys_rst = 1'b1;
        wr(4'hF, 32'h1000, 32'd1);
        sys_rst = 1'b0;
        chk("r6_status", status, 2'd0);
        chk("r6_done", done, 1'b0);
        chk("r6_halt", halt_req, 1'b0);
        chk("r6_failnum", fail_testnum, 31'd0);
        chk("r6_count", cycle_count, 32'd0);
        chk("r6_ign", ignored_wr, 8'd0);
        wr(4'hF, 32'h1000, 32'd1);
        chk("r6_pass", status, 2'd1);

        // Disabled watchdog: runs past any limit, ignored count saturates
        do_reset(1);
        step(40);
        chk("nowd_status", status_n, 2'd0);
        chk("nowd_count", cycle_count_n, 32'd40);
        for (int i = 0; i < 260; i++) begin
            wr(4'hF, 32'h1000, 32'h0000_0000);
        end
        chk("nowd_sat", ignored_wr_n, 8'hFF);
        chk("nowd_state", status_n, 2'd0);
        chk("nowd_done", done_n, 1'b0);
        chk("nowd_count2", cycle_count_n, 32'd300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
